plab2_proc_mul_arbiter: RTL and testbench

- Shares one plab1_imul_IntMulVarLat multiply unit between p_nreqs requesters, e.g. several pipelined cores or a core plus an accelerator.
- Sits between each requester's mul_req/mul_resp val/rdy ports and the single multiplier instance.
- Arbitrates requests round-robin, keeps exactly one transaction outstanding, and returns each response only to the requester that issued it.

---
 rtl/plab2_proc_mul_arb_pkg.sv | 20 ++
 rtl/plab2_proc_RoundRobinArbiter.sv | 33 +++
 rtl/plab2_proc_mul_arbiter.sv | 139 +++++++++++++
 tb/tb_plab2_proc_mul_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/plab2_proc_mul_arb_pkg.sv
// Shared definitions for the shared-multiplier arbiter: FSM encoding and owner width.
// Optional TDM slot arbitration is enabled with PLAB2_PROC_MUL_ARB_TDM_EN.
`ifndef PLAB1_IMUL_MULDIV_REQ_MSG_NBITS
`define PLAB1_IMUL_MULDIV_REQ_MSG_NBITS 67
`endif

package plab2_proc_mul_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  // Owner/pointer width; never zero so a degenerate single-requester build still elaborates.
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/plab2_proc_RoundRobinArbiter.sv
// Rotating-priority pick: first asserted val at or above rr_ptr, wrapping modulo p_nreqs.
module plab2_proc_RoundRobinArbiter
  import plab2_proc_mul_arb_pkg::*;
#(
  parameter int p_nreqs = 2,
  localparam int OW     = owner_w(p_nreqs)
) (
  input  logic [p_nreqs-1:0] val,
  input  logic [OW-1:0]      rr_ptr,
  output logic [p_nreqs-1:0] grant,
  output logic [OW-1:0]      winner,
  output logic               any
);

  always_comb begin
    int idx;
    idx    = 0;
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    // Walk from the farthest candidate back to rr_ptr so the nearest one is written last.
    for (int k = p_nreqs - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= p_nreqs) idx = idx - p_nreqs;
      if (val[idx]) begin
        winner = OW'(idx);
        any    = 1'b1;
      end
    end
    if (any) grant[winner] = 1'b1;
  end

endmodule

// File: rtl/plab2_proc_mul_arbiter.sv
// Shares one variable-latency multiplier among p_nreqs requesters, one transaction in flight.
// Define PLAB2_PROC_MUL_ARB_TDM_EN for fixed time-slot grants instead of round-robin.
`ifndef PLAB1_IMUL_MULDIV_REQ_MSG_NBITS
`define PLAB1_IMUL_MULDIV_REQ_MSG_NBITS 67
`endif

module plab2_proc_mul_arbiter
  import plab2_proc_mul_arb_pkg::*;
#(
  parameter int p_nreqs       = 2,
  parameter int p_slot_cycles = 16,
  parameter int p_msg_nbits   = `PLAB1_IMUL_MULDIV_REQ_MSG_NBITS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [p_nreqs-1:0]             req_val,
  output logic [p_nreqs-1:0]             req_rdy,
  input  logic [p_nreqs*p_msg_nbits-1:0] req_msg,
  output logic [p_nreqs-1:0]             resp_val,
  input  logic [p_nreqs-1:0]             resp_rdy,
  output logic [31:0]                    resp_msg,
  output logic                           mul_req_val,
  input  logic                           mul_req_rdy,
  output logic [p_msg_nbits-1:0]         mul_req_msg,
  input  logic                           mul_resp_val,
  output logic                           mul_resp_rdy,
  input  logic [31:0]                    mul_resp_msg,
  input  logic                           sd
);

  localparam int OW = owner_w(p_nreqs);

  arb_state_e             state_q, state_d;
  logic [OW-1:0]          owner_q, owner_d;
  logic [OW-1:0]          rr_q, rr_d;
  logic [p_msg_nbits-1:0] msg_q, msg_d;

  logic [p_nreqs-1:0] arb_val, grant;
  logic [OW-1:0]      arb_ptr, winner;
  logic               any;

  // Domain label is carried for information-flow analysis only.
  logic unused_sd;
  assign unused_sd = sd;

`ifdef PLAB2_PROC_MUL_ARB_TDM_EN
  localparam int SW = (p_slot_cycles > 1) ? $clog2(p_slot_cycles) : 1;

  logic [SW-1:0]      slot_cnt_q;
  logic [OW-1:0]      slot_own_q;
  logic [p_nreqs-1:0] slot_mask;
  logic               window;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt_q <= '0;
      slot_own_q <= '0;
    end else if (slot_cnt_q == SW'(p_slot_cycles - 1)) begin
      slot_cnt_q <= '0;
      slot_own_q <= (slot_own_q == OW'(p_nreqs - 1)) ? '0 : slot_own_q + 1'b1;
    end else begin
      slot_cnt_q <= slot_cnt_q + 1'b1;
    end
  end

  // Grants close early so an accept-issue pair cannot spill into the next owner's slot.
  assign window = (slot_cnt_q <= SW'(p_slot_cycles - 4));

  always_comb begin
    slot_mask             = '0;
    slot_mask[slot_own_q] = 1'b1;
  end

  assign arb_val = window ? (req_val & slot_mask) : '0;
  assign arb_ptr = slot_own_q;
`else
  assign arb_val = req_val;
  assign arb_ptr = rr_q;
`endif

  plab2_proc_RoundRobinArbiter #(.p_nreqs(p_nreqs)) u_rr (
    .val    (arb_val),
    .rr_ptr (arb_ptr),
    .grant  (grant),
    .winner (winner),
    .any    (any)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      msg_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      msg_q   <= msg_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_d         = rr_q;
    msg_d        = msg_q;
    req_rdy      = '0;
    resp_val     = '0;
    mul_req_val  = 1'b0;
    mul_resp_rdy = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated by reset so no grant is offered while reset is held.
        if (reset && any) begin
          req_rdy = grant;
          owner_d = winner;
          msg_d   = req_msg[int'(winner)*p_msg_nbits +: p_msg_nbits];
          rr_d    = (winner == OW'(p_nreqs - 1)) ? '0 : winner + 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mul_req_val = 1'b1;
        if (mul_req_rdy) state_d = WAIT;
      end
      WAIT: begin
        resp_val[owner_q] = mul_resp_val;
        mul_resp_rdy      = resp_rdy[owner_q];
        if (mul_resp_val && resp_rdy[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mul_req_msg = msg_q;
  assign resp_msg    = mul_resp_msg;

endmodule

// File: tb/tb_plab2_proc_mul_arbiter.sv
// Scoreboard bench for the shared-multiplier arbiter with a small variable-latency multiplier model.
module tb_plab2_proc_mul_arbiter;
  localparam int NR = 2;
  localparam int W  = 67;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_val, req_rdy, resp_val, resp_rdy;
  logic [NR*W-1:0] req_msg;
  logic [31:0]     resp_msg, mul_resp_msg;
  logic            mul_req_val, mul_req_rdy, mul_resp_val, mul_resp_rdy, sd;
  logic [W-1:0]    mul_req_msg;
  logic            mreq_en = 1'b1;

  always #5 clk = ~clk;

  plab2_proc_mul_arbiter #(.p_nreqs(NR), .p_slot_cycles(16), .p_msg_nbits(W)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
    .mul_req_val(mul_req_val), .mul_req_rdy(mul_req_rdy), .mul_req_msg(mul_req_msg),
    .mul_resp_val(mul_resp_val), .mul_resp_rdy(mul_resp_rdy), .mul_resp_msg(mul_resp_msg),
    .sd(sd)
  );

  typedef struct {int req; logic [31:0] prod;} exp_t;
  exp_t         sb_q[$];
  logic [W-1:0] msg_exp_q[$];
  int           order_q[$];
  logic [31:0]  exp_prod [NR];
  int           n_pass = 0, n_total = 0;

  // Multiplier model: 3 idle cycles after accept, then holds the result until taken.
  initial begin
    bit rf, pf, busy;
    int cnt;
    logic [31:0] a_s, b_s;
    busy = 0; cnt = 0;
    mul_req_rdy = 0; mul_resp_val = 0; mul_resp_msg = 32'hDEADBEEF;
    forever begin
      @(negedge clk);
      rf  = mul_req_val && mul_req_rdy;
      pf  = mul_resp_val && mul_resp_rdy;
      a_s = mul_req_msg[63:32];
      b_s = mul_req_msg[31:0];
      @(posedge clk); #1;
      if (!reset) begin
        busy = 0; mul_resp_val = 0;
      end else if (rf) begin
        busy = 1; cnt = 2; mul_resp_msg = a_s * b_s;
      end else if (pf) begin
        busy = 0; mul_resp_val = 0;
      end else if (busy && !mul_resp_val) begin
        if (cnt == 0) mul_resp_val = 1;
        else cnt--;
      end
      mul_req_rdy = !busy && mreq_en && reset;
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [W-1:0] mk(input logic [31:0] a, input logic [31:0] b);
    return {3'b000, a, b};
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        sb_q.delete();
        msg_exp_q.delete();
      end else begin
        for (int i = 0; i < NR; i++)
          if (req_val[i] && req_rdy[i]) begin
            sb_q.push_back('{i, exp_prod[i]});
            msg_exp_q.push_back(req_msg[i*W +: W]);
          end
        if (mul_req_val && mul_req_rdy) begin
          chk("mul_req_pending", W'(msg_exp_q.size() > 0), 1);
          if (msg_exp_q.size() > 0) chk("mul_req_msg", mul_req_msg, msg_exp_q.pop_front());
        end
        for (int i = 0; i < NR; i++)
          if (resp_val[i] && resp_rdy[i]) begin
            chk("resp_pending", W'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
              e = sb_q.pop_front();
              chk("resp_owner", W'(i), W'(e.req));
              chk("resp_msg", W'(resp_msg), W'(e.prod));
            end
          end
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
    exp_prod[i]        = p;
    req_msg[i*W +: W]  = mk(a, b);
    req_val[i]         = 1'b1;
  endtask

  task automatic wait_accept(input logic [NR-1:0] mask);
    logic [NR-1:0] seen, newb;
    int c;
    seen = '0; c = 0;
    while ((seen & mask) != mask && c < 100) begin
      @(negedge clk);
      newb = req_val & req_rdy & mask & ~seen;
      for (int i = 0; i < NR; i++) if (newb[i]) order_q.push_back(i);
      seen |= newb;
      @(posedge clk); #1;
      req_val &= ~newb;
      c++;
    end
    chk("accept", W'(seen & mask), W'(mask));
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while ((sb_q.size() != 0 || msg_exp_q.size() != 0) && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("drain", W'(sb_q.size() + msg_exp_q.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_resp(input int i);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!resp_val[i] && c < 100);
    chk("resp_val_seen", W'(resp_val[i]), 1);
  endtask

  task automatic both_order(input int first, input int second);
    chk("order_len", W'(order_q.size()), 2);
    chk("order_first", W'(order_q.size() > 0 ? order_q[0] : -1), W'(first));
    chk("order_second", W'(order_q.size() > 1 ? order_q[1] : -1), W'(second));
  endtask

  initial begin
    reset = 1'b0; req_val = '1; req_msg = '0; resp_rdy = '1; sd = 1'b0;
    for (int i = 0; i < NR; i++) exp_prod[i] = '0;
    fork monitor(); join_none

    // Reset state with both requesters already asking
    #12;
    chk("rst_req_rdy", W'(req_rdy), 0);
    chk("rst_resp_val", W'(resp_val), 0);
    chk("rst_mul_req_val", W'(mul_req_val), 0);
    chk("rst_mul_resp_rdy", W'(mul_resp_rdy), 0);
    chk("rst_resp_msg", W'(resp_msg), W'(32'hDEADBEEF));
    req_val = '0;
    cyc(1);
    reset = 1'b1;
    cyc(1);
    chk("idle_req_rdy", W'(req_rdy), 0);

    // Simultaneous requests after reset: 0 then 1, pointer wraps back to 0
    issue(0, 5, 6, 30); issue(1, 11, 13, 143); #1;
    chk("grant_both_a", W'(req_rdy), W'(2'b01));
    order_q.delete(); wait_accept(2'b11); wait_drain(); both_order(0, 1);
    issue(0, 2, 100, 200); issue(1, 9, 9, 81);
    order_q.delete(); wait_accept(2'b11); wait_drain(); both_order(0, 1);

    // Single requester 0: 3*7
    issue(0, 3, 7, 21); #1;
    chk("grant_single0", W'(req_rdy), W'(2'b01));
    wait_accept(2'b01); wait_drain();

    // After serving 0 the pointer favours 1
    issue(0, 4, 4, 16); issue(1, 7, 8, 56); #1;
    chk("grant_both_b", W'(req_rdy), W'(2'b10));
    order_q.delete(); wait_accept(2'b11); wait_drain(); both_order(1, 0);

    // Multiplier not ready for 3 cycles in ISSUE
    mreq_en = 1'b0; cyc(1);
    issue(0, 1000, 1000, 32'd1000000);
    wait_accept(2'b01);
    repeat (3) begin
      @(negedge clk);
      chk("issue_stall_val", W'(mul_req_val), 1);
      chk("issue_stall_msg", mul_req_msg, mk(1000, 1000));
    end
    mreq_en = 1'b1;
    wait_drain();

    // Requester 1 withholds resp_rdy for 5 cycles while requester 0 waits
    resp_rdy[1] = 1'b0;
    issue(1, 32'hFFFF, 32'h10001, 32'hFFFFFFFF);
    wait_accept(2'b10);
    issue(0, 12, 5, 60);
    wait_resp(1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("wstall_mul_resp_rdy", W'(mul_resp_rdy), 0);
      chk("wstall_resp_val", W'(resp_val), W'(2'b10));
      chk("wstall_req_rdy", W'(req_rdy), 0);
    end
    @(posedge clk); #1;
    resp_rdy[1] = 1'b1;
    @(negedge clk);
    chk("wstall_release", W'(mul_resp_rdy), 1);
    @(posedge clk); #1;
    wait_accept(2'b01); wait_drain();

    // Reset during WAIT (owner 0) with requester 1 pending
    resp_rdy[0] = 1'b0;
    issue(0, 6, 9, 54);
    wait_accept(2'b01);
    wait_resp(0);
    issue(1, 1, 1, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_req_rdy", W'(req_rdy), 0);
    chk("arst_resp_val", W'(resp_val), 0);
    chk("arst_mul_req_val", W'(mul_req_val), 0);
    chk("arst_mul_resp_rdy", W'(mul_resp_rdy), 0);
    req_val = '0; resp_rdy = '1;
    cyc(2);
    reset = 1'b1;
    cyc(1);
    chk("post_rst_req_rdy", W'(req_rdy), 0);

    // Pointer restarted at 0; zero operand and truncating product
    issue(0, 12, 12, 144); issue(1, 0, 12345, 0); #1;
    chk("post_rst_grant", W'(req_rdy), W'(2'b01));
    order_q.delete(); wait_accept(2'b11); wait_drain(); both_order(0, 1);
    issue(1, 32'h12345678, 32'h10, 32'h23456780);
    wait_accept(2'b10); wait_drain();
    issue(0, 32'h80000000, 2, 32'h0);
    wait_accept(2'b01); wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
